ariane_regfile_sb: RTL
======================

# ariane_regfile_sb

Parametrised flip-flop register file with an integrated per-register busy scoreboard and optional write-to-read bypass. It is the next-generation architectural register file for the issue/commit path. It generalises depth, data width and port counts, and adds busy tracking, flush and same-cycle forwarding. Issue allocates destinations. Commit writes clear them. Readers receive data plus a valid flag.

## Interface
- DATA_WIDTH, 64, data bits per register
- NR_REGS, 32, register count; power of two, ≥2; ADDR_W = $clog2(NR_REGS)
- NR_READ_PORTS, 2, read ports
- NR_WRITE_PORTS, 2, write (commit) ports
- NR_ALLOC_PORTS, 1, busy-allocate (issue) ports
- ZERO_REG_ZERO, 1, register 0 reads as 0, is never busy, and ignores writes and allocations
- BYPASS, 1, forward same-cycle write data to reads
- RESET_MEM, 0, 1 = storage cleared on reset; 0 = storage left unreset (unconstrained for formal)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- flush_i  in  1  clear all busy bits
- alloc_valid_i  in  NR_ALLOC_PORTS  allocate request
- alloc_addr_i  in  NR_ALLOC_PORTS×ADDR_W  register to mark busy
- we_i  in  NR_WRITE_PORTS  write enable
- waddr_i  in  NR_WRITE_PORTS×ADDR_W  write address
- wdata_i  in  NR_WRITE_PORTS×DATA_WIDTH  write data
- raddr_i  in  NR_READ_PORTS×ADDR_W  read address
- rdata_o  out  NR_READ_PORTS×DATA_WIDTH  read data
- rvalid_o  out  NR_READ_PORTS  data is final (register not busy, or bypassed)
- busy_o  out  NR_REGS  busy vector
- busy_cnt_o  out  ADDR_W+1  number of busy registers

## Operation
- Storage is mem[NR_REGS]. busy[NR_REGS] is a register. busy_cnt is a register kept equal to popcount(busy).
- Write: on we_i[j], mem[waddr_i[j]] ← wdata_i[j] at the next edge. busy[waddr_i[j]] is cleared.
- Write-write conflict on the same address: the highest port index wins.
- Allocate: alloc_valid_i[k] sets busy[alloc_addr_i[k]] at the next edge.
- Allocate and write to the same register in the same cycle: the allocate wins (busy = 1) and the data is still written. This is a new producer.
- flush_i: all busy bits go to 0 at the next edge and busy_cnt goes to 0. flush overrides allocates in the same cycle. Writes in the same cycle still update mem.
- Read (combinational):
  - Default: rdata = mem[raddr], rvalid = ~busy[raddr].
  - If BYPASS and some we_i[j] has waddr_i[j] == raddr: rdata = wdata of the highest such j, and rvalid = 1.
- ZERO_REG_ZERO: address 0 gives rdata = 0 and rvalid = 1. Writes and allocates to address 0 are dropped. busy[0] stays 0.
- Reset:
  - busy is cleared and busy_cnt = 0.
  - If RESET_MEM, mem is cleared to 0; otherwise mem is untouched.
  - Reset outputs: busy_o = 0, busy_cnt_o = 0. rvalid_o = 1 for all ports. rdata_o = mem contents: 0 if RESET_MEM, otherwise unconstrained. Register 0 reads 0 if ZERO_REG_ZERO.
- busy_cnt update:
  - next = popcount(next busy); a registered popcount is acceptable.
  - It must never exceed NR_REGS and must never wrap below 0.

## Timing
- Read latency is 0 cycles, combinational from raddr, mem, busy and the bypass inputs.
- Write-to-read latency is 1 cycle without bypass, 0 cycles with BYPASS.
- Allocate is visible on rvalid_o, busy_o and busy_cnt_o in the cycle after the edge.
- Reset mid-operation: asynchronous clear takes effect immediately. Pending same-cycle alloc/write inputs are ignored while rst_i = 1.
- No combinational path from alloc_* to any output.

## Structure
- Shared package ariane_regfile_pkg:
  - addr_w(NR_REGS) function
  - regfile config struct (DATA_WIDTH, NR_REGS, port counts, flags)
- One sub-module, regfile_wr_decode. It takes the write ports and produces a per-register enable plus a selected-port index, with highest-index priority. It is reused for the bypass selection.

## Test plan
- Reset with RESET_MEM=1 → all rdata_o = 0, rvalid_o = 1, busy_cnt_o = 0; release and read regs 1..31 → 0.
- Alloc reg 5, next cycle read 5 → rvalid = 0, busy_cnt = 1. Then write 5 = 0xDEAD with BYPASS=1 → same cycle rdata = 0xDEAD, rvalid = 1. Next cycle → busy_cnt = 0.
- Both write ports target reg 7 (port0 = 0x11, port1 = 0x22) → mem[7] = 0x22. Same-cycle bypass read of 7 → 0x22.
- Alloc and write reg 9 in the same cycle → next cycle busy[9] = 1 and mem[9] = written data.
- Alloc regs 1, 2, 3 over three cycles, then flush together with alloc reg 4 → busy_o = 0, busy_cnt_o = 0.
- ZERO_REG_ZERO=1: write 0xFF and allocate reg 0 → read 0 gives 0 with rvalid = 1, busy_cnt unchanged. Assert rst_i mid-burst → busy clears asynchronously.

Source files
------------

// File: rtl/ariane_regfile_pkg.sv
// Shared configuration types and sizing helpers for the scoreboarded register file.
package ariane_regfile_pkg;

  typedef struct packed {
    int unsigned data_width;
    int unsigned nr_regs;
    int unsigned nr_read_ports;
    int unsigned nr_write_ports;
    int unsigned nr_alloc_ports;
    bit          zero_reg_zero;
    bit          bypass;
    bit          reset_mem;
  } regfile_cfg_t;

  function automatic int unsigned addr_w(input int unsigned nr_regs);
    return (nr_regs > 1) ? $clog2(nr_regs) : 1;
  endfunction

  function automatic int unsigned sel_w(input int unsigned nr_ports);
    return (nr_ports > 1) ? $clog2(nr_ports) : 1;
  endfunction

endpackage

// File: rtl/regfile_wr_decode.sv
// Per-register write enable and winning-port index; the highest port index wins on conflicts.
module regfile_wr_decode
  import ariane_regfile_pkg::*;
#(
  parameter int unsigned NR_PORTS = 2,
  parameter int unsigned NR_REGS  = 32,
  localparam int unsigned ADDR_W  = addr_w(NR_REGS),
  localparam int unsigned SEL_W   = sel_w(NR_PORTS)
) (
  input  logic [NR_PORTS-1:0]        i_we,
  input  logic [NR_PORTS*ADDR_W-1:0] i_addr,
  output logic [NR_REGS-1:0]         o_en,
  output logic [NR_REGS*SEL_W-1:0]   o_sel
);

  // Ascending scan: later (higher) ports overwrite the selection of earlier ones.
  always_comb begin
    o_en  = '0;
    o_sel = '0;
    for (int p = 0; p < int'(NR_PORTS); p++) begin
      if (i_we[p]) begin
        o_en[i_addr[p*ADDR_W +: ADDR_W]] = 1'b1;
        o_sel[i_addr[p*ADDR_W +: ADDR_W]*SEL_W +: SEL_W] = SEL_W'(p);
      end
    end
  end

endmodule

// File: rtl/ariane_regfile_sb.sv
// Flip-flop register file with per-register busy scoreboard, flush and optional write-to-read bypass.
module ariane_regfile_sb
  import ariane_regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned NR_REGS        = 32,
  parameter int unsigned NR_READ_PORTS  = 2,
  parameter int unsigned NR_WRITE_PORTS = 2,
  parameter int unsigned NR_ALLOC_PORTS = 1,
  parameter bit          ZERO_REG_ZERO  = 1'b1,
  parameter bit          BYPASS         = 1'b1,
  parameter bit          RESET_MEM      = 1'b0,
  localparam int unsigned ADDR_W        = addr_w(NR_REGS)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  logic [NR_ALLOC_PORTS-1:0]            alloc_valid_i,
  input  logic [NR_ALLOC_PORTS*ADDR_W-1:0]     alloc_addr_i,
  input  logic [NR_WRITE_PORTS-1:0]            we_i,
  input  logic [NR_WRITE_PORTS*ADDR_W-1:0]     waddr_i,
  input  logic [NR_WRITE_PORTS*DATA_WIDTH-1:0] wdata_i,
  input  logic [NR_READ_PORTS*ADDR_W-1:0]      raddr_i,
  output logic [NR_READ_PORTS*DATA_WIDTH-1:0]  rdata_o,
  output logic [NR_READ_PORTS-1:0]             rvalid_o,
  output logic [NR_REGS-1:0]                   busy_o,
  output logic [ADDR_W:0]                      busy_cnt_o
);

  localparam regfile_cfg_t CFG = '{
    data_width:     DATA_WIDTH,
    nr_regs:        NR_REGS,
    nr_read_ports:  NR_READ_PORTS,
    nr_write_ports: NR_WRITE_PORTS,
    nr_alloc_ports: NR_ALLOC_PORTS,
    zero_reg_zero:  ZERO_REG_ZERO,
    bypass:         BYPASS,
    reset_mem:      RESET_MEM
  };
  localparam int unsigned SEL_W = sel_w(NR_WRITE_PORTS);
  localparam logic [NR_REGS-1:0] ZERO_MASK =
    CFG.zero_reg_zero ? {{(NR_REGS-1){1'b1}}, 1'b0} : {NR_REGS{1'b1}};

  logic [DATA_WIDTH-1:0]    r_mem [NR_REGS];
  logic [NR_REGS-1:0]       r_busy;
  logic [ADDR_W:0]          r_busy_cnt;

  logic [NR_REGS-1:0]       w_wr_en;
  logic [NR_REGS-1:0]       w_mem_we;
  logic [NR_REGS*SEL_W-1:0] w_wr_sel;
  logic [NR_REGS-1:0]       w_alloc_en;
  logic [NR_REGS-1:0]       w_busy_next;
  logic [ADDR_W:0]          w_busy_cnt_next;
  logic [DATA_WIDTH-1:0]    w_wdata     [NR_WRITE_PORTS];
  logic [DATA_WIDTH-1:0]    w_reg_wdata [NR_REGS];

  regfile_wr_decode #(
    .NR_PORTS (NR_WRITE_PORTS),
    .NR_REGS  (NR_REGS)
  ) u_wr_decode (
    .i_we   (we_i),
    .i_addr (waddr_i),
    .o_en   (w_wr_en),
    .o_sel  (w_wr_sel)
  );

  genvar gi;
  for (gi = 0; gi < NR_WRITE_PORTS; gi++) begin : g_wport
    assign w_wdata[gi] = wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Winning write data per register; shared by the storage update and the read bypass.
  for (gi = 0; gi < NR_REGS; gi++) begin : g_regsel
    assign w_reg_wdata[gi] = w_wdata[w_wr_sel[gi*SEL_W +: SEL_W]];
  end

  assign w_mem_we = w_wr_en & ZERO_MASK;

  always_comb begin
    w_alloc_en = '0;
    for (int k = 0; k < int'(NR_ALLOC_PORTS); k++) begin
      if (alloc_valid_i[k]) w_alloc_en[alloc_addr_i[k*ADDR_W +: ADDR_W]] = 1'b1;
    end
  end

  // Priority: flush > allocate (new producer) > write (producer retired) > hold.
  always_comb begin
    w_busy_next = (r_busy & ~w_wr_en) | w_alloc_en;
    if (flush_i) w_busy_next = '0;
    w_busy_next = w_busy_next & ZERO_MASK;
  end

  always_comb begin
    w_busy_cnt_next = '0;
    for (int i = 0; i < int'(NR_REGS); i++) begin
      w_busy_cnt_next = w_busy_cnt_next + {{ADDR_W{1'b0}}, w_busy_next[i]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_next;
      r_busy_cnt <= w_busy_cnt_next;
    end
  end

  if (CFG.reset_mem) begin : g_mem_rst
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < int'(NR_REGS); i++) r_mem[i] <= '0;
      end else begin
        for (int i = 0; i < int'(NR_REGS); i++) begin
          if (w_mem_we[i]) r_mem[i] <= w_reg_wdata[i];
        end
      end
    end
  end else begin : g_mem_norst
    always_ff @(posedge clk_i) begin
      if (!rst_i) begin
        for (int i = 0; i < int'(NR_REGS); i++) begin
          if (w_mem_we[i]) r_mem[i] <= w_reg_wdata[i];
        end
      end
    end
  end

  for (gi = 0; gi < NR_READ_PORTS; gi++) begin : g_rd
    logic [ADDR_W-1:0]     w_raddr;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_rvalid;

    assign w_raddr = raddr_i[gi*ADDR_W +: ADDR_W];

    always_comb begin
      w_rdata  = r_mem[w_raddr];
      w_rvalid = ~r_busy[w_raddr];
      if (CFG.bypass && w_wr_en[w_raddr]) begin
        w_rdata  = w_reg_wdata[w_raddr];
        w_rvalid = 1'b1;
      end
      if (CFG.zero_reg_zero && (w_raddr == '0)) begin
        w_rdata  = '0;
        w_rvalid = 1'b1;
      end
    end

    assign rdata_o[gi*DATA_WIDTH +: DATA_WIDTH] = w_rdata;
    assign rvalid_o[gi]                         = w_rvalid;
  end

  assign busy_o     = r_busy;
  assign busy_cnt_o = r_busy_cnt;

endmodule
